// File: rtl/g_draw_sched_if.sv
// rtl/g_draw_sched_if.sv - request/draw bus between grill slots and the sprite-draw scheduler
//
// master: the grill-slot side (drives requests, slot geometry and colours)
// slave : the scheduler (drives grant/done/busy and the datapath/VGA controls)
interface g_draw_sched_if #(
    parameter int N_SLOTS = 4
);
    logic [N_SLOTS-1:0]   req;
    logic [N_SLOTS-1:0]   req_erase;
    logic [8*N_SLOTS-1:0] x_pos;
    logic [8*N_SLOTS-1:0] y_pos;
    logic [9*N_SLOTS-1:0] colour_fat_in;
    logic [9*N_SLOTS-1:0] colour_muscle_in;
    logic [N_SLOTS-1:0]   grant;
    logic [N_SLOTS-1:0]   done;
    logic                 busy;
    logic [4:0]           pix_idx;
    logic                 layer;
    logic [7:0]           x_adder;
    logic [7:0]           y_adder;
    logic [8:0]           colour_fat;
    logic [8:0]           colour_muscle;
    logic                 plot;

    modport master (
        output req, req_erase, x_pos, y_pos, colour_fat_in, colour_muscle_in,
        input  grant, done, busy, pix_idx, layer, x_adder, y_adder,
               colour_fat, colour_muscle, plot
    );

    modport slave (
        input  req, req_erase, x_pos, y_pos, colour_fat_in, colour_muscle_in,
        output grant, done, busy, pix_idx, layer, x_adder, y_adder,
               colour_fat, colour_muscle, plot
    );
endinterface

// File: rtl/g_draw_sched.sv
// rtl/g_draw_sched.sv - round-robin sprite-draw sequencer shared by N grill slots
//
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   vga_ready     (only with G_SCHED_STALL_EN) pixel accept from the VGA adapter
//   bus           g_draw_sched_if.slave: req/req_erase/x_pos/y_pos/colour_*_in in,
//                 grant/done/busy/pix_idx/layer/x_adder/y_adder/colour_*/plot out
// Optional feature macro: G_SCHED_STALL_EN
module g_draw_sched #(
    parameter int         N_SLOTS       = 4,
    parameter int         FAT_PIXELS    = 21,
    parameter int         MUSCLE_PIXELS = 16,
    parameter logic [8:0] BG_COLOUR     = 9'h000
) (
    input logic clk,
    input logic resetn,
`ifdef G_SCHED_STALL_EN
    input logic vga_ready,
`endif
    g_draw_sched_if.slave bus
);
    localparam int         IW          = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam logic [4:0] FAT_LAST    = 5'(FAT_PIXELS - 1);
    localparam logic [4:0] MUSCLE_LAST = 5'(MUSCLE_PIXELS - 1);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_FAT, S_MUSCLE, S_DONE} state_t;

    state_t state, state_d;

    logic [N_SLOTS-1:0] grant_q, grant_d;
    logic [N_SLOTS-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic [4:0]         pix_q, pix_d;
    logic               layer_q, layer_d;
    logic [7:0]         x_q, x_d;
    logic [7:0]         y_q, y_d;
    logic [8:0]         cf_q, cf_d;
    logic [8:0]         cm_q, cm_d;
    logic               plot_q, plot_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      sel;
    logic               advance;

`ifdef G_SCHED_STALL_EN
    assign advance = vga_ready;
`else
    assign advance = 1'b1;
`endif

    // First requesting slot at or above the RR pointer, wrapping. Scanning
    // from the farthest offset down lets the nearest one overwrite the rest.
    always_comb begin
        sel = rr_q;
        for (int k = N_SLOTS - 1; k >= 0; k--) begin
            if (bus.req[(int'(rr_q) + k) % N_SLOTS]) begin
                sel = IW'((int'(rr_q) + k) % N_SLOTS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            pix_q   <= '0;
            layer_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            cf_q    <= '0;
            cm_q    <= '0;
            plot_q  <= 1'b0;
            rr_q    <= '0;
            gidx_q  <= '0;
        end else begin
            state   <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            pix_q   <= pix_d;
            layer_q <= layer_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cf_q    <= cf_d;
            cm_q    <= cm_d;
            plot_q  <= plot_d;
            rr_q    <= rr_d;
            gidx_q  <= gidx_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (|bus.req) state_d = S_ARB;
            S_ARB:    state_d = S_FAT;
            S_FAT:    if (advance && pix_q == FAT_LAST) state_d = S_MUSCLE;
            S_MUSCLE: if (advance && pix_q == MUSCLE_LAST) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so this computes the values they take in the
    // cycle after the current one; plot is raised one edge ahead of each pixel.
    always_comb begin
        grant_d = grant_q;
        done_d  = '0;
        busy_d  = (state_d != S_IDLE);
        pix_d   = pix_q;
        layer_d = layer_q;
        x_d     = x_q;
        y_d     = y_q;
        cf_d    = cf_q;
        cm_d    = cm_q;
        plot_d  = 1'b0;
        rr_d    = rr_q;
        gidx_d  = gidx_q;
        case (state)
            S_IDLE: begin
                if (|bus.req) begin
                    grant_d = {{(N_SLOTS-1){1'b0}}, 1'b1} << sel;
                    gidx_d  = sel;
                    x_d     = bus.x_pos[8*int'(sel) +: 8];
                    y_d     = bus.y_pos[8*int'(sel) +: 8];
                    if (bus.req_erase[sel]) begin
                        cf_d = BG_COLOUR;
                        cm_d = BG_COLOUR;
                    end else begin
                        cf_d = bus.colour_fat_in[9*int'(sel) +: 9];
                        cm_d = bus.colour_muscle_in[9*int'(sel) +: 9];
                    end
                    pix_d   = '0;
                    layer_d = 1'b0;
                end
            end
            S_ARB: begin
                pix_d   = '0;
                layer_d = 1'b0;
                plot_d  = 1'b1;
            end
            S_FAT: begin
                if (advance) begin
                    plot_d = 1'b1;
                    if (pix_q == FAT_LAST) begin
                        pix_d   = '0;
                        layer_d = 1'b1;
                    end else begin
                        pix_d = pix_q + 5'd1;
                    end
                end
            end
            S_MUSCLE: begin
                if (advance) begin
                    if (pix_q == MUSCLE_LAST) begin
                        pix_d   = '0;
                        layer_d = 1'b0;
                        done_d  = grant_q;
                    end else begin
                        pix_d  = pix_q + 5'd1;
                        plot_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                grant_d = '0;
                rr_d    = (gidx_q == IW'(N_SLOTS - 1)) ? '0 : gidx_q + 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.grant         = grant_q;
    assign bus.done          = done_q;
    assign bus.busy          = busy_q;
    assign bus.pix_idx       = pix_q;
    assign bus.layer         = layer_q;
    assign bus.x_adder       = x_q;
    assign bus.y_adder       = y_q;
    assign bus.colour_fat    = cf_q;
    assign bus.colour_muscle = cm_q;
    assign bus.plot          = plot_q;
endmodule

// File: tb/tb_g_draw_sched.sv
// tb/tb_g_draw_sched.sv - self-checking bench for g_draw_sched
module tb_g_draw_sched;
    localparam int N       = 4;
    localparam int FAT     = 21;
    localparam int MUS     = 16;
    localparam int PIX_END = FAT + MUS;
    localparam int TDONE   = FAT + MUS + 1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int errors = 0;

    g_draw_sched_if #(.N_SLOTS(N)) bus ();

`ifdef G_SCHED_STALL_EN
    logic vga_ready = 1'b1;
    int   stall_pix = -1;
    int   stall_cnt = 0;
`endif

    g_draw_sched #(
        .N_SLOTS(N), .FAT_PIXELS(FAT), .MUSCLE_PIXELS(MUS), .BG_COLOUR(9'h000)
    ) dut (
        .clk(clk),
        .resetn(resetn),
`ifdef G_SCHED_STALL_EN
        .vga_ready(vga_ready),
`endif
        .bus(bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: one service is a timeline t = 0 (arbitration) .. TDONE (done).
    bit         m_live = 0;
    bit         m_active = 0;
    bit         m_stall = 0;
    int         m_t = 0, m_slot = 0, m_rr = 0, mi = 0;
    logic [7:0] m_x = 0, m_y = 0;
    logic [8:0] m_cf = 0, m_cm = 0;

    always @(posedge clk) begin
        m_live = 1;
        if (!resetn) begin
            m_active = 0; m_t = 0; m_rr = 0; m_slot = 0; m_stall = 0;
            m_x = 0; m_y = 0; m_cf = 0; m_cm = 0;
        end else if (!m_active) begin
            m_stall = 0;
            for (int k = 0; k < N; k++) begin
                mi = (m_rr + k) % N;
                if (!m_active && bus.req[mi]) begin
                    m_active = 1; m_t = 0; m_slot = mi;
                    m_x  = bus.x_pos[8*mi +: 8];
                    m_y  = bus.y_pos[8*mi +: 8];
                    m_cf = bus.req_erase[mi] ? 9'h000 : bus.colour_fat_in[9*mi +: 9];
                    m_cm = bus.req_erase[mi] ? 9'h000 : bus.colour_muscle_in[9*mi +: 9];
                end
            end
        end else if (m_t == TDONE) begin
            m_active = 0;
            m_rr = (m_slot + 1) % N;
        end else begin
            m_stall = 0;
`ifdef G_SCHED_STALL_EN
            if (m_t >= 1 && m_t <= PIX_END && !vga_ready) m_stall = 1;
`endif
            if (!m_stall) m_t++;
        end
    end

    logic [3:0] e_grant, e_done;
    logic       e_busy, e_layer, e_plot;
    logic [4:0] e_pix;
    always @(negedge clk) begin
        if (m_live) begin
            e_grant = m_active ? (4'b0001 << m_slot) : 4'b0000;
            e_done  = (m_active && m_t == TDONE) ? (4'b0001 << m_slot) : 4'b0000;
            e_busy  = m_active;
            e_plot  = m_active && m_t >= 1 && m_t <= PIX_END && !m_stall;
            e_layer = m_active && m_t > FAT && m_t <= PIX_END;
            if (m_active && m_t >= 1 && m_t <= FAT) e_pix = 5'(m_t - 1);
            else if (e_layer) e_pix = 5'(m_t - FAT - 1);
            else e_pix = 5'd0;
            tests++;
            if ({bus.grant, bus.done, bus.busy, bus.pix_idx, bus.layer, bus.x_adder, bus.y_adder,
                 bus.colour_fat, bus.colour_muscle, bus.plot} !==
                {e_grant, e_done, e_busy, e_pix, e_layer, m_x, m_y, m_cf, m_cm, e_plot}) begin
                errors++;
                $display("FAIL cycle @%0t: got grant=%b done=%b busy=%b pix=%0d layer=%b x=%0d y=%0d cf=%h cm=%h plot=%b; expected grant=%b done=%b busy=%b pix=%0d layer=%b x=%0d y=%0d cf=%h cm=%h plot=%b",
                         $time, bus.grant, bus.done, bus.busy, bus.pix_idx, bus.layer, bus.x_adder,
                         bus.y_adder, bus.colour_fat, bus.colour_muscle, bus.plot,
                         e_grant, e_done, e_busy, e_pix, e_layer, m_x, m_y, m_cf, m_cm, e_plot);
            end
        end
    end

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Entered at a negedge just after req has been raised for 'slot'.
    task automatic serve(input int slot, input int drop_after,
                         input logic [7:0] ex, input logic [7:0] ey,
                         input logic [8:0] ecf, input logic [8:0] ecm,
                         output int p0, output int p1, output int badx, output int badc,
                         output int cyc, output int done_at, output logic [3:0] first_grant);
        bit got;
        got = 0; p0 = 0; p1 = 0; badx = 0; badc = 0; cyc = 0; done_at = 0; first_grant = 4'b0000;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 0) first_grant = bus.grant;
            if (bus.busy) cyc++;
            if (bus.plot) begin
                if (bus.layer) p1++; else p0++;
                if (bus.x_adder !== ex || bus.y_adder !== ey) badx++;
                if (bus.colour_fat !== ecf || bus.colour_muscle !== ecm) badc++;
            end
            if (drop_after > 0 && p0 + p1 == drop_after && bus.req[slot]) begin
                bus.req[slot] = 1'b0;
                bus.x_pos[8*slot +: 8] = 8'd99;
            end
`ifdef G_SCHED_STALL_EN
            if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0) vga_ready = 1'b1;
            end else if (stall_pix >= 0 && bus.plot && !bus.layer && int'(bus.pix_idx) == stall_pix) begin
                vga_ready = 1'b0;
                stall_cnt = 3;
                stall_pix = -1;
            end
`endif
            if (!got && bus.done[slot]) begin
                got = 1;
                done_at = cyc;
                bus.req[slot] = 1'b0;
            end
            if (got && !bus.busy) break;
        end
        check("serve_done_seen", 64'(got), 64'd1);
    endtask

    int p0, p1, badx, badc, cyc, done_at, plots, idle_run, ngr;
    logic [3:0] fg, prev_grant;
    int order [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req = '0;
        bus.req_erase = '0;
        bus.x_pos = {8'd40, 8'd10, 8'd33, 8'd5};
        bus.y_pos = {8'd44, 8'd20, 8'd22, 8'd7};
        bus.colour_fat_in = {9'h0AA, 9'h155, 9'h0F0, 9'h1C0};
        bus.colour_muscle_in = {9'h011, 9'h022, 9'h033, 9'h044};
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", 64'(bus.grant), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_plot", 64'(bus.plot), 64'd0);
        check("rst_pix", 64'(bus.pix_idx), 64'd0);
        check("rst_x", 64'(bus.x_adder), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Single slot 2 service
        bus.req = 4'b0100;
        serve(2, 0, 8'd10, 8'd20, 9'h155, 9'h022, p0, p1, badx, badc, cyc, done_at, fg);
        check("t1_first_grant", 64'(fg), 64'b0100);
        check("t1_fat_plots", 64'(p0), 64'd21);
        check("t1_muscle_plots", 64'(p1), 64'd16);
        check("t1_bad_xy", 64'(badx), 64'd0);
        check("t1_done_at", 64'(done_at), 64'd39);
        check("t1_busy_cycles", 64'(cyc), 64'd39);

        // Round robin under constant full request
        do_reset();
        bus.req = 4'b1111;
        prev_grant = 4'b0000; idle_run = 0; ngr = 0;
        for (int c = 0; c < 400 && ngr < 5; c++) begin
            @(negedge clk);
            if (bus.grant != 4'b0000 && prev_grant == 4'b0000) begin
                if (ngr > 0) check("t2_idle_gap", 64'(idle_run), 64'd1);
                for (int b = 0; b < N; b++) if (bus.grant[b]) order[ngr] = b;
                ngr++;
            end
            if (!bus.busy) idle_run++; else idle_run = 0;
            prev_grant = bus.grant;
        end
        check("t2_grants_seen", 64'(ngr), 64'd5);
        check("t2_order0", 64'(order[0]), 64'd0);
        check("t2_order1", 64'(order[1]), 64'd1);
        check("t2_order2", 64'(order[2]), 64'd2);
        check("t2_order3", 64'(order[3]), 64'd3);
        check("t2_order4", 64'(order[4]), 64'd0);
        bus.req = 4'b0000;
        for (int c = 0; c < 100 && bus.busy; c++) @(negedge clk);
        check("t2_idle_after", 64'(bus.busy), 64'd0);

        // Erase pass on slot 0
        do_reset();
        bus.req_erase = 4'b0001;
        bus.req = 4'b0001;
        serve(0, 0, 8'd5, 8'd7, 9'h000, 9'h000, p0, p1, badx, badc, cyc, done_at, fg);
        check("t3_bg_colour", 64'(badc), 64'd0);
        check("t3_plots", 64'(p0 + p1), 64'd37);
        bus.req_erase = 4'b0000;
        @(negedge clk);

        // req dropped and x changed mid-service on slot 1
        bus.req = 4'b0010;
        serve(1, 5, 8'd33, 8'd22, 9'h0F0, 9'h033, p0, p1, badx, badc, cyc, done_at, fg);
        check("t4_plots", 64'(p0 + p1), 64'd37);
        check("t4_latched_x", 64'(badx), 64'd0);
        check("t4_done_at", 64'(done_at), 64'd39);

        // Reset during the 10th fat plot
        do_reset();
        bus.req = 4'b0001;
        plots = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.plot) plots++;
            if (plots == 10) break;
        end
        check("t5_reached_plot10", 64'(plots), 64'd10);
        resetn = 1'b0;
        bus.req = 4'b0000;
        @(negedge clk);
        check("t5_plot", 64'(bus.plot), 64'd0);
        check("t5_grant", 64'(bus.grant), 64'd0);
        check("t5_busy", 64'(bus.busy), 64'd0);
        check("t5_done", 64'(bus.done), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        bus.req = 4'b0001;
        serve(0, 0, 8'd5, 8'd7, 9'h1C0, 9'h044, p0, p1, badx, badc, cyc, done_at, fg);
        check("t5_resume_plots", 64'(p0 + p1), 64'd37);
        check("t5_resume_done_at", 64'(done_at), 64'd39);

`ifdef G_SCHED_STALL_EN
        // Three-cycle stall at fat pixel 7
        do_reset();
        stall_pix = 7;
        bus.req = 4'b0001;
        serve(0, 0, 8'd5, 8'd7, 9'h1C0, 9'h044, p0, p1, badx, badc, cyc, done_at, fg);
        check("t6_busy_cycles", 64'(cyc), 64'd42);
        check("t6_plots", 64'(p0 + p1), 64'd37);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
